sha_stream_padder: RTL

Streaming SHA-256 message padder: accepts a message one byte per cycle over a valid/ready handshake and emits 512-bit padded blocks to the hash core. It is the producer side of the `padded` interface consumed by `sha256`. It supports arbitrary-length, multi-block messages: it appends 0x80, zero fill and the 64-bit big-endian bit length, inserting an extra block when required.

---
 rtl/sha_stream_padder_if.sv | 23 ++
 rtl/sha_stream_padder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sha_stream_padder_if.sv
// Byte-in / block-out bus of the SHA-256 padder.
// master: the padder itself; slave: the byte source plus block consumer.
interface sha_stream_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    modport master (
        input  in_data, in_valid, in_last, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    modport slave (
        output in_data, in_valid, in_last, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );
endinterface

// File: rtl/sha_stream_padder.sv
// Streaming SHA-256 padder: packs bytes into 512-bit blocks and appends 0x80,
// zero fill and the 64-bit big-endian bit length, adding an extra block if needed.
module sha_stream_padder #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    sha_stream_padder_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_PAD    = 3'd2,
        ST_OUT    = 3'd3,
        ST_LENBLK = 3'd4
    } state_e;

    state_e           state_q,    state_d;
    logic [511:0]     buf_q,      buf_d;
    logic [6:0]       pos_q,      pos_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             pad_pend_q, pad_pend_d;
    logic             len_pend_q, len_pend_d;
    logic             last_q,     last_d;
    logic             later_q,    later_d;
    logic [63:0]      len_s;

    // Byte idx lives at bits [511-8*idx -: 8], i.e. base 8*(63-idx) = {~idx,3'b000}.
    function automatic logic [511:0] put_byte(input logic [511:0] b,
                                              input logic [5:0]   idx,
                                              input logic [7:0]   v);
        logic [511:0] r;
        r = b;
        r[{~idx, 3'b000} +: 8] = v;
        return r;
    endfunction

    assign len_s = 64'(cnt_q) << 3'd3;

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.blk_valid = (state_q == ST_OUT);
    assign bus.blk_data  = buf_q;
    assign bus.blk_first = (state_q == ST_OUT) && !later_q;
    assign bus.blk_last  = (state_q == ST_OUT) && last_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= 512'd0;
            pos_q      <= 7'd0;
            cnt_q      <= '0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
            last_q     <= 1'b0;
            later_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            pad_pend_q <= pad_pend_d;
            len_pend_q <= len_pend_d;
            last_q     <= last_d;
            later_q    <= later_d;
        end
    end

    // Next-state and buffer update. The buffer is all-zero past pos at all
    // times (cleared on reset and on every block handshake), so padding only
    // has to place 0x80 and the length.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        pad_pend_d = pad_pend_q;
        len_pend_d = len_pend_q;
        last_d     = last_q;
        later_d    = later_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    buf_d = put_byte(buf_q, pos_q[5:0], bus.in_data);
                    pos_d = pos_q + 7'd1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (pos_q == 7'd63) begin
                        state_d    = ST_OUT;
                        pad_pend_d = bus.in_last;
                        last_d     = 1'b0;
                    end else if (bus.in_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_PAD: begin
                buf_d = put_byte(buf_q, pos_q[5:0], 8'h80);
                if (pos_q <= 7'd55) begin
                    buf_d[63:0] = len_s;
                    last_d      = 1'b1;
                end else begin
                    len_pend_d = 1'b1;
                    last_d     = 1'b0;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.blk_ready) begin
                    later_d = 1'b1;
                    buf_d   = 512'd0;
                    if (len_pend_q) begin
                        state_d = ST_LENBLK;
                    end else if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        pos_d      = 7'd0;
                        state_d    = ST_PAD;
                    end else if (last_q) begin
                        cnt_d   = '0;
                        pos_d   = 7'd0;
                        last_d  = 1'b0;
                        later_d = 1'b0;
                        state_d = ST_FILL;
                    end else begin
                        pos_d   = 7'd0;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_LENBLK: begin
                buf_d      = {448'd0, len_s};
                last_d     = 1'b1;
                len_pend_d = 1'b0;
                state_d    = ST_OUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
